// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 streaming convolution.
//   state_t        : frame sequencing states (FILL, RUN, DRAIN)
//   kernel_t       : 9-tap kernel in raster order, integer form; the top
//                    narrows each tap to its COEF_W-bit register width
//   DEFAULT_KERNEL : Laplacian kernel loaded at reset
//   GUARD_BITS     : headroom added to the product width for the 9-term sum
//   tap_depth()    : pixel distance from the newest pixel to a window tap
package conv_pkg;

    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

    localparam int unsigned NTAP       = 9;
    localparam int unsigned GUARD_BITS = 4;

    typedef int kernel_t [NTAP];

    localparam kernel_t DEFAULT_KERNEL = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};

    // Tap t (0 = top-left, 8 = bottom-right) sits this many pixels behind the
    // newest pixel in the raster stream for a line width of w.
    function automatic int unsigned tap_depth(input int unsigned t, input int unsigned w);
        return (2 - t / 3) * w + (2 - t % 3);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Two-line plus three-pixel window shift register.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : shift one pixel in
//   zero_in    : the pixel shifted in is zero instead of din
//   clr        : clear all stored pixels (the incoming pixel is still kept
//                when en is also high, so it becomes the first of a new frame)
//   din        : incoming packed pixel
//   taps       : 3x3 window in raster order; tap 8 is the incoming pixel
//                itself, so the window reflects the state after this shift
module line_buffer
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 320,
    parameter int unsigned PW    = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  zero_in,
    input  logic                  clr,
    input  logic [PW-1:0]         din,
    output logic [NTAP-1:0][PW-1:0] taps
);

    localparam int unsigned DEPTH = 2 * IMG_W + 2;

    logic [PW-1:0] sr [DEPTH];
    logic [PW-1:0] head;

    assign head = zero_in ? '0 : din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (en) begin
            sr[0] <= head;
            for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= clr ? '0 : sr[i-1];
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
        end
    end

    for (genvar t = 0; t < NTAP; t++) begin : g_tap
        localparam int unsigned D = tap_depth(t, IMG_W);
        if (D == 0) begin : g_head
            assign taps[t] = head;
        end else begin : g_reg
            assign taps[t] = sr[D-1];
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution with zero-padded borders, runtime kernel,
// end-of-frame drain and valid/ready backpressure.
//   clk, rst_n        : clock, asynchronous active-low reset
//   x_data/x_valid/x_sof/x_ready : input pixel stream (channel c at [c*CW +: CW])
//   y_data/y_valid/y_ready       : filtered pixel stream, registered output
//   coef_wr/coef_idx/coef_data   : shadow kernel write port (tap 0..8 raster)
//   err_sync          : one-cycle pulse when x_sof arrives mid-frame
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 320,
    parameter int unsigned IMG_H  = 240,
    parameter int unsigned CH     = 3,
    parameter int unsigned CW     = 10,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned SHIFT  = 0,
    parameter int unsigned ABS    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH*CW-1:0]         x_data,
    input  logic                     x_valid,
    input  logic                     x_sof,
    output logic                     x_ready,
    output logic [CH*CW-1:0]         y_data,
    output logic                     y_valid,
    input  logic                     y_ready,
    input  logic                     coef_wr,
    input  logic [3:0]               coef_idx,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     err_sync
);

    localparam int unsigned PIXW  = CH * CW;
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned CNT_W = $clog2(NPIX);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned PW    = CW + 1 + COEF_W;
    localparam int unsigned SW    = PW + GUARD_BITS;
    localparam logic signed [SW:0] SAT_MAX = (SW+1)'((1 << CW) - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   in_cnt, cnt_n;
    logic [COL_W-1:0]   c_col;
    logic [ROW_W-1:0]   c_row;
    logic               advance, acc_px, resync, commit, drain_slot, emit;

    logic signed [COEF_W-1:0] sh_k  [NTAP];
    logic signed [COEF_W-1:0] act_k [NTAP];

    logic [NTAP-1:0][PIXW-1:0] taps, taps_m;
    logic [PIXW-1:0]           mac_out;

    assign advance    = ~y_valid | y_ready;
    assign x_ready    = rst_n & advance & (state != DRAIN);
    assign acc_px     = x_valid & x_ready;
    // in_cnt is only zero for the first pixel of a frame, so any other sof is a resync
    assign resync     = acc_px & x_sof & (in_cnt != '0);
    assign commit     = acc_px & ((in_cnt == '0) | x_sof);
    assign drain_slot = (state == DRAIN) & advance;
    assign emit       = ((state == RUN) & acc_px & ~resync) | drain_slot;

    line_buffer #(
        .IMG_W (IMG_W),
        .PW    (PIXW)
    ) u_lb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (acc_px | drain_slot),
        .zero_in (state == DRAIN),
        .clr     (resync),
        .din     (x_data),
        .taps    (taps)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FILL;
            in_cnt <= '0;
        end else begin
            state  <= state_n;
            in_cnt <= cnt_n;
        end
    end

    // in_cnt counts accepted pixels in FILL/RUN and drain slots in DRAIN
    always_comb begin
        state_n = state;
        cnt_n   = in_cnt;
        if (resync) begin
            state_n = FILL;
            cnt_n   = CNT_W'(1);
        end else begin
            unique case (state)
                FILL: if (acc_px) begin
                    cnt_n = in_cnt + CNT_W'(1);
                    if (in_cnt == CNT_W'(IMG_W)) state_n = RUN;
                end
                RUN: if (acc_px) begin
                    if (in_cnt == CNT_W'(NPIX - 1)) begin
                        state_n = DRAIN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = in_cnt + CNT_W'(1);
                    end
                end
                DRAIN: if (advance) begin
                    if (in_cnt == CNT_W'(IMG_W)) begin
                        state_n = FILL;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = in_cnt + CNT_W'(1);
                    end
                end
                default: state_n = FILL;
            endcase
        end
    end

    // Position of the pixel currently at the window centre
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_col <= '0;
            c_row <= '0;
        end else if (resync) begin
            c_col <= '0;
            c_row <= '0;
        end else if (emit) begin
            if (c_col == COL_W'(IMG_W - 1)) begin
                c_col <= '0;
                c_row <= (c_row == ROW_W'(IMG_H - 1)) ? '0 : c_row + ROW_W'(1);
            end else begin
                c_col <= c_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned t = 0; t < NTAP; t++) begin
                sh_k[t]  <= COEF_W'(DEFAULT_KERNEL[t]);
                act_k[t] <= COEF_W'(DEFAULT_KERNEL[t]);
            end
        end else begin
            // act_k takes the pre-write shadow, so a same-cycle write lands next frame
            if (commit) begin
                for (int unsigned t = 0; t < NTAP; t++) act_k[t] <= sh_k[t];
            end
            if (coef_wr) begin
                for (int unsigned t = 0; t < NTAP; t++) begin
                    if (coef_idx == 4'(t)) sh_k[t] <= coef_data;
                end
            end
        end
    end

    // Taps falling outside the frame read as zero, which also hides any
    // stale pixels from the previous line or frame.
    always_comb begin
        for (int unsigned t = 0; t < NTAP; t++) begin
            taps_m[t] = taps[t];
            if ((t < 3 && c_row == '0) ||
                (t > 5 && c_row == ROW_W'(IMG_H - 1)) ||
                (t % 3 == 0 && c_col == '0) ||
                (t % 3 == 2 && c_col == COL_W'(IMG_W - 1)))
                taps_m[t] = '0;
        end
    end

    logic signed [CW:0]   mac_pix;
    logic signed [PW-1:0] mac_prod;
    logic signed [SW-1:0] mac_acc, mac_shv;
    logic signed [SW:0]   mac_mag;

    always_comb begin
        mac_out  = '0;
        mac_pix  = '0;
        mac_prod = '0;
        mac_acc  = '0;
        mac_shv  = '0;
        mac_mag  = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            mac_acc = '0;
            for (int unsigned t = 0; t < NTAP; t++) begin
                mac_pix  = signed'({1'b0, taps_m[t][c*CW +: CW]});
                mac_prod = PW'(mac_pix) * PW'(act_k[t]);
                mac_acc  = mac_acc + SW'(mac_prod);
            end
            mac_shv = mac_acc >>> SHIFT;
            mac_mag = (SW+1)'(mac_shv);
            if (ABS != 0 && mac_shv < 0) mac_mag = -mac_mag;
            if (mac_mag < 0)
                mac_out[c*CW +: CW] = '0;
            else if (mac_mag > SAT_MAX)
                mac_out[c*CW +: CW] = '1;
            else
                mac_out[c*CW +: CW] = mac_mag[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid  <= 1'b0;
            y_data   <= '0;
            err_sync <= 1'b0;
        end else begin
            err_sync <= resync;
            if (advance) begin
                y_valid <= emit;
                if (emit) y_data <= mac_out;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream on a 4x3 frame. Two instances
// (ABS=0 and ABS=1) share the same stimulus; a frame-level reference model
// computes the expected outputs directly from the zero-padded convolution.
module tb_conv3x3_stream;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NCH  = 3;
    localparam int BW   = 10;
    localparam int KW   = 8;
    localparam int SH   = 0;
    localparam int NPIX = W * H;
    localparam int PMAX = (1 << BW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH*BW-1:0]    x_data, y_data, y_data_a;
    logic                 x_valid, x_sof, x_ready, x_ready_a;
    logic                 y_valid, y_valid_a, y_ready;
    logic                 coef_wr;
    logic [3:0]           coef_idx;
    logic signed [KW-1:0] coef_data;
    logic                 err_sync, err_sync_a;

    always #5 clk = ~clk;

    conv3x3_stream #(
        .IMG_W(W), .IMG_H(H), .CH(NCH), .CW(BW), .COEF_W(KW), .SHIFT(SH), .ABS(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .x_data(x_data), .x_valid(x_valid), .x_sof(x_sof), .x_ready(x_ready),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
        .coef_wr(coef_wr), .coef_idx(coef_idx), .coef_data(coef_data),
        .err_sync(err_sync)
    );

    conv3x3_stream #(
        .IMG_W(W), .IMG_H(H), .CH(NCH), .CW(BW), .COEF_W(KW), .SHIFT(SH), .ABS(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .x_data(x_data), .x_valid(x_valid), .x_sof(x_sof), .x_ready(x_ready_a),
        .y_data(y_data_a), .y_valid(y_valid_a), .y_ready(y_ready),
        .coef_wr(coef_wr), .coef_idx(coef_idx), .coef_data(coef_data),
        .err_sync(err_sync_a)
    );

    typedef struct packed {
        logic [NCH*BW-1:0] d0;
        logic [NCH*BW-1:0] d1;
    } exp_t;

    int   def_k [9] = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    int   k_sh  [9];
    int   k_act [9];
    int   frm   [NPIX][NCH];
    exp_t expq  [$];

    int n_checks  = 0;
    int n_fail    = 0;
    int err_cnt   = 0;
    int err_cnt_a = 0;
    int out_cnt   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp_px(input int v, input bit mag);
        int r;
        r = v;
        if (mag && r < 0) r = -r;
        if (r < 0) return 0;
        if (r > PMAX) return PMAX;
        return r;
    endfunction

    // Expected outputs for the first 'count' centre pixels of the frame in frm[]
    task automatic push_expected(input int count);
        for (int n = 0; n < count; n++) begin
            exp_t e;
            int   r, c, s;
            r = n / W;
            c = n % W;
            e = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                s = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
                            s += k_act[(dr + 1) * 3 + (dc + 1)] * frm[(r + dr) * W + (c + dc)][ch];
                s = s >>> SH;
                e.d0[ch*BW +: BW] = BW'(clamp_px(s, 1'b0));
                e.d1[ch*BW +: BW] = BW'(clamp_px(s, 1'b1));
            end
            expq.push_back(e);
        end
    endtask

    // One clock: inputs are already driven at the falling edge; sample just
    // after, score any output handshake, then move to the next falling edge.
    task automatic step(output bit acc);
        #1;
        acc = x_valid && x_ready;
        if (y_valid && !y_ready) begin
            check("x_ready_backpressure", x_ready, 0);
            check("x_ready_backpressure_abs", x_ready_a, 0);
        end
        if (y_valid && y_ready) begin
            out_cnt++;
            check("output_expected", expq.size() != 0, 1);
            if (expq.size() != 0) begin
                exp_t e;
                e = expq.pop_front();
                check("y_data", y_data, e.d0);
                check("y_data_abs", y_data_a, e.d1);
                check("y_valid_abs", y_valid_a, 1);
            end
        end
        if (err_sync)   err_cnt++;
        if (err_sync_a) err_cnt_a++;
        @(negedge clk);
    endtask

    task automatic send_frame(input int npix, input int rdy_pct, input bit load_ident);
        int sent;
        int budget;
        bit acc;
        sent   = 0;
        budget = 0;
        while (sent < npix && budget < 1000) begin
            x_valid = 1'b1;
            x_sof   = (sent == 0);
            for (int ch = 0; ch < NCH; ch++) x_data[ch*BW +: BW] = BW'(frm[sent][ch]);
            y_ready   = ($urandom_range(99) < rdy_pct);
            coef_wr   = load_ident && sent >= 1 && sent <= 9;
            coef_idx  = 4'(sent - 1);
            coef_data = (sent == 5) ? 8'sd1 : 8'sd0;
            step(acc);
            if (acc && sent == 0) begin
                k_act = k_sh;
                push_expected(npix == NPIX ? NPIX : (npix > W + 1 ? npix - (W + 1) : 0));
            end
            if (coef_wr) k_sh[coef_idx] = int'(coef_data);
            if (acc) sent++;
            budget++;
        end
        check("send_complete", sent, npix);
        x_valid = 1'b0;
        x_sof   = 1'b0;
        coef_wr = 1'b0;
    endtask

    task automatic flush(input int rdy_pct);
        int budget;
        bit acc;
        budget  = 0;
        x_valid = 1'b0;
        while (expq.size() != 0 && budget < 500) begin
            y_ready = ($urandom_range(99) < rdy_pct);
            step(acc);
            budget++;
        end
        check("all_outputs_seen", expq.size(), 0);
        y_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(acc);
    endtask

    task automatic write_random_kernel();
        bit acc;
        for (int t = 0; t < 9; t++) begin
            int v;
            v         = int'($urandom_range(16)) - 8;
            coef_wr   = 1'b1;
            coef_idx  = 4'(t);
            coef_data = KW'(v);
            y_ready   = 1'b1;
            step(acc);
            k_sh[t] = v;
        end
        coef_wr = 1'b0;
    endtask

    task automatic fill_random();
        for (int p = 0; p < NPIX; p++)
            for (int ch = 0; ch < NCH; ch++) frm[p][ch] = int'($urandom_range(PMAX));
    endtask

    task automatic run_frame(input string tag, input int rdy_pct, input bit load_ident);
        int oc0;
        oc0 = out_cnt;
        send_frame(NPIX, rdy_pct, load_ident);
        flush(rdy_pct);
        check(tag, out_cnt - oc0, NPIX);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int oc0;
        rst_n = 1'b1; x_valid = 1'b0; x_sof = 1'b0; x_data = '0; y_ready = 1'b1;
        coef_wr = 1'b0; coef_idx = '0; coef_data = '0;
        k_sh  = def_k;
        k_act = def_k;

        #2 rst_n = 1'b0;
        #1;
        check("reset_y_valid", y_valid, 0);
        check("reset_y_data", y_data, 0);
        check("reset_x_ready", x_ready, 0);
        check("reset_err_sync", err_sync, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Constant 100 frame, free-flowing then 50% backpressure
        for (int p = 0; p < NPIX; p++) for (int ch = 0; ch < NCH; ch++) frm[p][ch] = 100;
        run_frame("count_const_ready", 100, 1'b0);
        run_frame("count_const_bp", 50, 1'b0);

        // Single bright pixel at (1,1)
        for (int p = 0; p < NPIX; p++) for (int ch = 0; ch < NCH; ch++) frm[p][ch] = 0;
        for (int ch = 0; ch < NCH; ch++) frm[1 * W + 1][ch] = 1000;
        run_frame("count_point", 70, 1'b0);

        // Identity kernel written during frame 0, effective from frame 1
        fill_random();
        run_frame("count_ident_f0", 100, 1'b1);
        fill_random();
        run_frame("count_ident_f1", 80, 1'b0);

        // Random kernel, random pixels
        write_random_kernel();
        fill_random();
        run_frame("count_rand_kernel", 60, 1'b0);

        // Mid-frame resync: 5 pixels, then sof on the next pixel
        check("err_sync_quiet", err_cnt, 0);
        fill_random();
        send_frame(5, 100, 1'b0);
        fill_random();
        oc0 = out_cnt;
        send_frame(NPIX, 100, 1'b0);
        flush(100);
        check("count_after_resync", out_cnt - oc0, NPIX);
        check("err_sync_pulses", err_cnt, 1);
        check("err_sync_pulses_abs", err_cnt_a, 1);

        // Reset asserted while draining
        write_random_kernel();
        fill_random();
        send_frame(NPIX, 100, 1'b0);
        y_ready = 1'b1;
        step(acc);
        check("drain_y_valid", y_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_drops_y_valid", y_valid, 0);
        check("rst_drops_y_valid_abs", y_valid_a, 0);
        check("rst_x_ready", x_ready, 0);
        expq.delete();
        k_sh  = def_k;
        k_act = def_k;
        @(negedge clk);
        rst_n = 1'b1;
        fill_random();
        run_frame("count_after_reset", 100, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Parametrised 3x3 streaming convolution for the raster video path: one multi-channel pixel in, one filtered pixel out, same frame geometry.
- Generalises the fixed-Laplacian edge filter:
  - runtime-loadable signed kernel with frame-boundary commit;
  - zero-padded borders;
  - end-of-frame drain;
  - full valid/ready backpressure;
  - optional magnitude output.
- Sits between the camera/pixel source and the display or threshold stage.

## Interface
- IMG_W, 320, pixels per line (≥ 3)
- IMG_H, 240, lines per frame (≥ 2)
- CH, 3, channels per pixel
- CW, 10, unsigned bits per channel
- COEF_W, 8, signed coefficient width
- SHIFT, 0, arithmetic right shift applied to each channel sum
- ABS, 0, 1 = take magnitude of the shifted sum before saturation
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- x_data  in  CH*CW  input pixel; channel c at [c*CW +: CW]
- x_valid  in  1  input pixel valid
- x_sof  in  1  start of frame, qualified by x_valid&x_ready
- x_ready  out  1  block accepts input this cycle
- y_data  out  CH*CW  filtered pixel, same packing
- y_valid  out  1  output valid (registered)
- y_ready  in  1  downstream accepts
- coef_wr  in  1  write strobe into shadow kernel
- coef_idx  in  4  tap 0..8, raster order (0 = top-left, 4 = centre)
- coef_data  in  COEF_W  signed coefficient
- err_sync  out  1  one-cycle pulse on mid-frame x_sof resync

## Operation
- Reset values:
  - y_valid = 0, y_data = 0, err_sync = 0, x_ready = 0 while rst_n low;
  - state = FILL, all counters = 0;
  - active and shadow kernel = {-1,-1,-1,-1,8,-1,-1,-1,-1}.
- Define advance = ~y_valid | y_ready. One pipeline; everything stalls when advance = 0.
- x_ready = advance & (state != DRAIN).
- Line buffer holds 2*IMG_W+3 pixels. A pixel enters on an accepted input, or on an internal zero pixel during DRAIN.
- State FILL:
  - accepted pixels only fill the buffer;
  - after IMG_W+1 pixels, go to RUN.
- State RUN:
  - each accepted pixel k emits output for centre pixel k-(IMG_W+1);
  - after pixel IMG_W*IMG_H-1 is accepted, go to DRAIN.
- State DRAIN:
  - inserts IMG_W+1 zero pixels, one per advance cycle, each emitting one output;
  - then go to FILL.
- Every frame yields exactly IMG_W*IMG_H outputs, in raster order.
- Zero padding: the centre row/col counters mask taps outside the frame to 0. Taps must never read a neighbouring line or frame.
- Arithmetic, per channel:
  - product is signed (CW+1)×COEF_W;
  - sum of 9 products carries 4 guard bits;
  - then arithmetic >>SHIFT;
  - if ABS, take the magnitude;
  - saturate to [0, 2^CW-1].
- Kernel:
  - coef_wr writes the shadow kernel at any time;
  - shadow is copied to active when pixel index 0 of a frame is accepted;
  - a write in that same cycle lands in the next frame.
- Resync: an accepted x_sof=1 at pixel index ≠ 0 does the following:
  - pulses err_sync;
  - discards outstanding outputs;
  - clears the buffer;
  - restarts as pixel 0 of a new frame (state FILL, kernel commit).
- x_sof on the first pixel after reset is a normal start.

## Timing
- Output register: y_data/y_valid update only when advance = 1. They hold stable while y_valid & ~y_ready.
- Latency: the output for centre pixel n is valid the cycle after the accept of pixel n+IMG_W+1 (or the equivalent drain slot).
- Throughput: 1 pixel/cycle with y_ready held high.
- The DRAIN phase costs IMG_W+1 cycles with x_ready = 0.
- Async reset mid-operation drops y_valid immediately. The first accept is possible on the first clock edge after rst_n rises.

## Structure
- Package conv_pkg holds:
  - state enum {FILL, RUN, DRAIN};
  - kernel_t (9×COEF_W signed);
  - DEFAULT_KERNEL constant;
  - guard-bit localparam.
- Sub-module line_buffer: 2-line + 3-tap window shift register or RAM, with enable, zero-insert and clear inputs. It exposes the 9 window taps.
- Top holds the FSM, counters, kernel banks, MAC/saturation and the output register.

## Test plan
- Constant 100 frame (IMG_W=4, IMG_H=3), default kernel, y_ready=1:
  - output corners 500, edges 300, interior (1,1),(1,2) = 0;
  - exactly 12 outputs per frame.
- Same frame with y_ready randomly toggled 50%:
  - output sequence identical to the previous scenario, no drops or duplicates;
  - x_ready = 0 whenever y_valid & ~y_ready.
- Single pixel 1000 at (1,1) on zeros:
  - centre output saturates to 1023, 8 neighbours output 0;
  - with ABS=1, neighbours output 1000.
- Identity kernel (tap 4 = 1, rest 0) written mid-frame 0:
  - frame 0 output is still Laplacian;
  - frame 1 output equals its input bit-exactly.
- x_sof asserted at pixel 5 of a frame:
  - err_sync high for exactly one cycle;
  - next frame yields exactly 12 correct outputs.
- rst_n pulsed low during DRAIN:
  - y_valid = 0 the same cycle;
  - after release, state FILL, kernel back to default, next frame output correct.
